// File: rtl/c_fp_divider.sv
// Sequential IEEE-754 single-precision divider (div_r = a / b).
// Restoring mantissa division produces one quotient bit per clock.
// Rounding truncates, denormal inputs are flushed to zero, and one flag
// reports every exceptional outcome.
module c_fp_divider #(
   parameter int BIAS = 127,
   parameter int ITER = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] div_r,
   output logic        div_exception
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, PACK = 2'd2} state_t;

   state_t       state_reg, state_next;
   logic         sign_reg;
   logic [9:0]   exp_t_reg;
   logic [23:0]  mb_reg;
   logic [24:0]  rem_reg;
   logic [24:0]  q_reg;
   logic [CW-1:0] cnt_reg;
   logic         special_reg;
   logic [31:0]  spec_r_reg;
   logic         spec_exc_reg;
   logic         done_reg;
   logic [31:0]  div_r_reg;
   logic         exc_reg;

   // Operand field views of the live inputs (only used on the accepting edge)
   logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in;
   logic [9:0]   exp_t_in;
   logic         special_in;
   logic [31:0]  spec_r_in;
   logic         spec_exc_in;

   // Divider step and result packing
   logic         q_bit;
   logic [24:0]  rem_step;
   logic [24:0]  rem_diff;
   logic [22:0]  mant_pack;
   logic signed [9:0] e_pack;
   logic [31:0]  pack_r;
   logic         pack_exc;

   assign a_zero   = (a[30:23] == 8'h00);
   assign b_zero   = (b[30:23] == 8'h00);
   assign a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
   assign b_inf    = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
   assign a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
   assign b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
   assign sign_in  = a[31] ^ b[31];
   assign exp_t_in = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'(BIAS);

   // Classify the incoming operands; the first matching case wins
   always_comb begin
      special_in  = 1'b1;
      spec_r_in   = {sign_in, 31'd0};
      spec_exc_in = 1'b0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_r_in   = 32'h7FC0_0000;
         spec_exc_in = 1'b1;
      end else if (b_zero || a_inf) begin
         spec_r_in   = {sign_in, 8'hFF, 23'd0};
         spec_exc_in = 1'b1;
      end else if (a_zero || b_inf) begin
         spec_r_in   = {sign_in, 31'd0};
         spec_exc_in = 1'b0;
      end else begin
         special_in  = 1'b0;
      end
   end

   // One restoring-division iteration; rem stays below 2*mb so 25 bits suffice
   always_comb begin
      rem_diff = rem_reg - {1'b0, mb_reg};
      q_bit    = (rem_reg >= {1'b0, mb_reg});
      rem_step = q_bit ? {rem_diff[23:0], 1'b0} : {rem_reg[23:0], 1'b0};
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = special_in ? PACK : DIV;
         DIV:     if (cnt_reg == CW'(ITER - 1)) state_next = PACK;
         PACK:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: busy from state, plus the packed result presented to the PACK edge
   always_comb begin
      busy      = (state_reg != IDLE);
      mant_pack = q_reg[24] ? q_reg[23:1] : q_reg[22:0];
      e_pack    = q_reg[24] ? exp_t_reg : exp_t_reg - 10'd1;
      pack_r    = {sign_reg, e_pack[7:0], mant_pack};
      pack_exc  = 1'b0;
      if (special_reg) begin
         pack_r   = spec_r_reg;
         pack_exc = spec_exc_reg;
      end else if (e_pack >= 10'sd255) begin
         pack_r   = {sign_reg, 8'hFF, 23'd0};
         pack_exc = 1'b1;
      end else if (e_pack <= 10'sd0) begin
         pack_r   = {sign_reg, 31'd0};
         pack_exc = 1'b1;
      end
   end

   // Datapath: operand capture, quotient iteration and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sign_reg     <= 1'b0;
         exp_t_reg    <= 10'd0;
         mb_reg       <= 24'd0;
         rem_reg      <= 25'd0;
         q_reg        <= 25'd0;
         cnt_reg      <= '0;
         special_reg  <= 1'b0;
         spec_r_reg   <= 32'd0;
         spec_exc_reg <= 1'b0;
         done_reg     <= 1'b0;
         div_r_reg    <= 32'd0;
         exc_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  sign_reg     <= sign_in;
                  exp_t_reg    <= exp_t_in;
                  mb_reg       <= {1'b1, b[22:0]};
                  rem_reg      <= {2'b01, a[22:0]};
                  q_reg        <= 25'd0;
                  cnt_reg      <= '0;
                  special_reg  <= special_in;
                  spec_r_reg   <= spec_r_in;
                  spec_exc_reg <= spec_exc_in;
               end
            end
            DIV: begin
               rem_reg <= rem_step;
               q_reg   <= {q_reg[23:0], q_bit};
               cnt_reg <= cnt_reg + 1'b1;
            end
            PACK: begin
               div_r_reg <= pack_r;
               exc_reg   <= pack_exc;
               done_reg  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign done          = done_reg;
   assign div_r         = div_r_reg;
   assign div_exception = exc_reg;

endmodule
